// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and strobe sequencer for an asynchronous 256Kx8 SRAM.
// States: IDLE grant | RD OE pulse | WSETUP, WPULSE, WHOLD write phases | DONE ack, bus released
module sram_arbiter #(
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned WE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_rnw,
    input  logic [17:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic [7:0]  p0_rdata,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_rnw,
    input  logic [17:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic [7:0]  p1_rdata,
    output logic        p1_ack,
    output logic        busy,
    output logic        RAMCS_b,
    output logic        RAMOE_b,
    output logic        RAMWE_b,
    output logic [17:0] ADR,
    output logic [7:0]  dat_out,
    output logic        dat_oe,
    input  logic [7:0]  dat_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WSETUP, S_WPULSE, S_WHOLD, S_DONE
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        rnw_q, rnw_d;
    logic [17:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        cs_q, cs_d, oe_q, oe_d, we_q, we_d, doe_q, doe_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [7:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        sel;

    // Port 1 wins when alone, or when both ask and port 0 was served last.
    assign sel = p1_req & (~p0_req | ~last_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            rnw_q    <= 1'b1;
            addr_q   <= 18'd0;
            wdata_q  <= 8'd0;
            cs_q     <= 1'b1;
            oe_q     <= 1'b1;
            we_q     <= 1'b1;
            doe_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= 8'd0;
            rdata1_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cs_q     <= cs_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            doe_q    <= doe_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    gnt_d   = sel;
                    last_d  = sel;
                    rnw_d   = sel ? p1_rnw : p0_rnw;
                    addr_d  = sel ? p1_addr : p0_addr;
                    wdata_d = sel ? p1_wdata : p0_wdata;
                    if (rnw_d) begin
                        state_d = S_RD;
                        cnt_d   = RD_LOAD;
                    end else begin
                        state_d = S_WSETUP;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else cnt_d = cnt_q - 4'd1;
            end
            S_WSETUP: begin
                state_d = S_WPULSE;
                cnt_d   = WE_LOAD;
            end
            S_WPULSE: begin
                if (cnt_q == 4'd0) state_d = S_WHOLD;
                else cnt_d = cnt_q - 4'd1;
            end
            S_WHOLD: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the pins change on the same edge as the state.
    always_comb begin
        cs_d     = 1'b1;
        oe_d     = 1'b1;
        we_d     = 1'b1;
        doe_d    = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_d)
            S_RD: begin
                cs_d = 1'b0;
                oe_d = 1'b0;
            end
            S_WSETUP, S_WHOLD: begin
                cs_d  = 1'b0;
                doe_d = 1'b1;
            end
            S_WPULSE: begin
                cs_d  = 1'b0;
                doe_d = 1'b1;
                we_d  = 1'b0;
            end
            S_DONE: begin
                ack0_d = ~gnt_d;
                ack1_d = gnt_d;
            end
            default: ;
        endcase
        if (state_q == S_RD && cnt_q == 4'd0) begin
            if (gnt_q) rdata1_d = dat_in;
            else       rdata0_d = dat_in;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign RAMCS_b  = cs_q;
    assign RAMOE_b  = oe_q;
    assign RAMWE_b  = we_q;
    assign ADR      = addr_q;
    assign dat_out  = wdata_q;
    assign dat_oe   = doe_q;
    assign p0_ack   = ack0_q;
    assign p1_ack   = ack1_q;
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, hand sequences, and random traffic against a timeline model.
module tb_sram_arbiter;
    localparam int RD = 2;
    localparam int WE = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req = 1'b0, p0_rnw = 1'b1, p1_req = 1'b0, p1_rnw = 1'b1;
    logic [17:0] p0_addr = '0, p1_addr = '0, ADR;
    logic [7:0]  p0_wdata = '0, p1_wdata = '0, p0_rdata, p1_rdata, dat_out;
    logic [7:0]  dat_in = '0;
    logic        p0_ack, p1_ack, busy, RAMCS_b, RAMOE_b, RAMWE_b, dat_oe;

    always #5 clk = ~clk;

    sram_arbiter #(.RD_CYCLES(RD), .WE_CYCLES(WE)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_rnw(p0_rnw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_rnw(p1_rnw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .busy(busy), .RAMCS_b(RAMCS_b), .RAMOE_b(RAMOE_b), .RAMWE_b(RAMWE_b),
        .ADR(ADR), .dat_out(dat_out), .dat_oe(dat_oe), .dat_in(dat_in)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction timeline model: m_k is the cycle offset since the grant (0 = idle).
    int          m_k = 0;
    bit          m_port = 1'b0, m_rnw = 1'b1, m_last = 1'b1;
    logic [17:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_rd [2] = '{8'h00, 8'h00};

    function automatic int m_len();
        return m_rnw ? RD + 1 : WE + 3;
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            m_k = 0; m_last = 1'b1; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        end else if (m_k == 0) begin
            if (p0_req || p1_req) begin
                m_port  = (p0_req && p1_req) ? !m_last : p1_req;
                m_last  = m_port;
                m_rnw   = m_port ? p1_rnw : p0_rnw;
                m_addr  = m_port ? p1_addr : p0_addr;
                m_wdata = m_port ? p1_wdata : p0_wdata;
                m_k     = 1;
            end
        end else begin
            if (m_rnw && m_k == RD) m_rd[m_port] = dat_in;
            if (m_k == m_len()) m_k = 0;
            else m_k++;
        end
    endtask

    task automatic model_check();
        bit act_rd, act_w, pulse, done;
        act_rd = m_rnw && m_k >= 1 && m_k <= RD;
        act_w  = !m_rnw && m_k >= 1 && m_k <= WE + 2;
        pulse  = !m_rnw && m_k >= 2 && m_k <= WE + 1;
        done   = (m_k != 0) && (m_k == m_len());
        chk("m_busy", busy, m_k != 0);
        chk("m_cs", RAMCS_b, !(act_rd || act_w));
        chk("m_oe", RAMOE_b, !act_rd);
        chk("m_we", RAMWE_b, !pulse);
        chk("m_dat_oe", dat_oe, act_w);
        chk("m_ack0", p0_ack, done && !m_port);
        chk("m_ack1", p1_ack, done && m_port);
        chk("m_rdata0", p0_rdata, m_rd[0]);
        chk("m_rdata1", p1_rdata, m_rd[1]);
        if (act_rd || act_w) chk("m_adr", ADR, m_addr);
        if (act_w) chk("m_dat_out", dat_out, m_wdata);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        model_check();
        chk("no_contention", dat_oe & ~RAMOE_b, 0);
        chk("ack_overlap", p0_ack & p1_ack, 0);
    endtask

    typedef struct {
        bit rst_n, r0, rnw0, r1, rnw1;
        logic [7:0] din;
        logic [6:0] e;      // cs, oe, we, dat_oe, ack0, ack1, busy
        logic [7:0] rd0;
        logic [17:0] adr;
        logic [7:0] dout;
    } vec_t;

    function automatic vec_t v(bit rst_n, bit r0, bit rnw0, bit r1, bit rnw1, logic [7:0] din,
                               logic [6:0] e, logic [7:0] rd0, logic [17:0] adr, logic [7:0] dout);
        vec_t t;
        t.rst_n = rst_n; t.r0 = r0; t.rnw0 = rnw0; t.r1 = r1; t.rnw1 = rnw1; t.din = din;
        t.e = e; t.rd0 = rd0; t.adr = adr; t.dout = dout;
        return t;
    endfunction

    localparam logic [6:0] E_IDLE = 7'b1110000, E_RD = 7'b0010001, E_DN0 = 7'b1110101;
    localparam logic [6:0] E_WS = 7'b0111001, E_WP = 7'b0101001, E_DN1 = 7'b1110011;

    vec_t tv [21];
    int   gq [$];
    int   first_ack;

    initial begin
        tv[0]  = v(0, 1, 1, 1, 0, 8'hA5, E_IDLE, 8'h00, 18'h00000, 8'h00);
        tv[1]  = v(0, 1, 1, 1, 0, 8'hA5, E_IDLE, 8'h00, 18'h00000, 8'h00);
        tv[2]  = v(0, 1, 1, 1, 0, 8'hA5, E_IDLE, 8'h00, 18'h00000, 8'h00);
        tv[3]  = v(1, 1, 1, 1, 0, 8'hA5, E_RD,   8'h00, 18'h12345, 8'h00);
        tv[4]  = v(1, 1, 1, 1, 0, 8'hA5, E_RD,   8'h00, 18'h12345, 8'h00);
        tv[5]  = v(1, 1, 1, 1, 0, 8'hA5, E_DN0,  8'hA5, 18'h12345, 8'h00);
        tv[6]  = v(1, 0, 1, 1, 0, 8'hC3, E_IDLE, 8'hA5, 18'h12345, 8'h00);
        tv[7]  = v(1, 0, 1, 1, 0, 8'hC3, E_WS,   8'hA5, 18'h3FFFF, 8'h5A);
        tv[8]  = v(1, 0, 1, 1, 0, 8'hC3, E_WP,   8'hA5, 18'h3FFFF, 8'h5A);
        tv[9]  = v(1, 0, 1, 1, 0, 8'hC3, E_WP,   8'hA5, 18'h3FFFF, 8'h5A);
        tv[10] = v(1, 0, 1, 1, 0, 8'hC3, E_WP,   8'hA5, 18'h3FFFF, 8'h5A);
        tv[11] = v(1, 0, 1, 1, 0, 8'hC3, E_WS,   8'hA5, 18'h3FFFF, 8'h5A);
        tv[12] = v(1, 0, 1, 1, 0, 8'hC3, E_DN1,  8'hA5, 18'h3FFFF, 8'h5A);
        tv[13] = v(1, 0, 1, 0, 0, 8'hC3, E_IDLE, 8'hA5, 18'h3FFFF, 8'h5A);
        tv[14] = v(1, 1, 0, 0, 0, 8'hC3, E_WS,   8'hA5, 18'h12345, 8'h11);
        tv[15] = v(1, 1, 0, 0, 0, 8'hC3, E_WP,   8'hA5, 18'h12345, 8'h11);
        tv[16] = v(1, 1, 0, 0, 0, 8'hC3, E_WP,   8'hA5, 18'h12345, 8'h11);
        tv[17] = v(1, 1, 0, 0, 0, 8'hC3, E_WP,   8'hA5, 18'h12345, 8'h11);
        tv[18] = v(1, 1, 0, 0, 0, 8'hC3, E_WS,   8'hA5, 18'h12345, 8'h11);
        tv[19] = v(1, 1, 0, 0, 0, 8'hC3, E_DN0,  8'hA5, 18'h12345, 8'h11);
        tv[20] = v(1, 0, 0, 0, 0, 8'hC3, E_IDLE, 8'hA5, 18'h12345, 8'h11);

        p0_addr = 18'h12345; p0_wdata = 8'h11;
        p1_addr = 18'h3FFFF; p1_wdata = 8'h5A;
        #1;
        for (int i = 0; i < 21; i++) begin
            vec_t t;
            t = tv[i];
            reset_n = t.rst_n; p0_req = t.r0; p0_rnw = t.rnw0;
            p1_req = t.r1; p1_rnw = t.rnw1; dat_in = t.din;
            step();
            chk($sformatf("v%0d_cs", i), RAMCS_b, t.e[6]);
            chk($sformatf("v%0d_oe", i), RAMOE_b, t.e[5]);
            chk($sformatf("v%0d_we", i), RAMWE_b, t.e[4]);
            chk($sformatf("v%0d_dat_oe", i), dat_oe, t.e[3]);
            chk($sformatf("v%0d_ack0", i), p0_ack, t.e[2]);
            chk($sformatf("v%0d_ack1", i), p1_ack, t.e[1]);
            chk($sformatf("v%0d_busy", i), busy, t.e[0]);
            chk($sformatf("v%0d_rdata0", i), p0_rdata, t.rd0);
            chk($sformatf("v%0d_rdata1", i), p1_rdata, 8'h00);
            if (t.e[6] == 1'b0) chk($sformatf("v%0d_adr", i), ADR, t.adr);
            if (t.e[3] == 1'b1) chk($sformatf("v%0d_dout", i), dat_out, t.dout);
        end

        // Fairness: both ports hold their requests; grants must alternate starting with port 0.
        reset_n = 1'b0; step();
        reset_n = 1'b1; p0_req = 1'b1; p0_rnw = 1'b1; p1_req = 1'b1; p1_rnw = 1'b0;
        for (int c = 0; c < 200 && gq.size() < 6; c++) begin
            step();
            if (p0_ack) gq.push_back(0);
            if (p1_ack) gq.push_back(1);
        end
        chk("fair_count", gq.size(), 6);
        for (int i = 0; i < gq.size() && i < 6; i++) chk($sformatf("fair_grant%0d", i), gq[i], i % 2);

        // Reset in the middle of a write pulse.
        p0_req = 1'b0; p1_req = 1'b0; reset_n = 1'b0; step();
        reset_n = 1'b1; p1_req = 1'b1; p1_rnw = 1'b0; p1_wdata = 8'h77;
        step();
        step();
        chk("wpulse_we_low", RAMWE_b, 0);
        reset_n = 1'b0; step();
        chk("rst_we", RAMWE_b, 1);
        chk("rst_dat_oe", dat_oe, 0);
        chk("rst_cs", RAMCS_b, 1);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {p0_ack, p1_ack}, 0);
        reset_n = 1'b1; p0_req = 1'b1; p0_rnw = 1'b1;
        first_ack = -1;
        for (int c = 0; c < 30 && first_ack < 0; c++) begin
            step();
            if (p0_ack) first_ack = 0;
            else if (p1_ack) first_ack = 1;
        end
        chk("post_reset_first_grant", first_ack, 0);
        p0_req = 1'b0; p1_req = 1'b0;
        for (int c = 0; c < 10; c++) step();

        // Random traffic: requesters hold until ack, scramble inputs once granted, occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            dat_in = 8'($urandom);
            if (!p0_req && $urandom_range(0, 3) == 0) begin
                p0_req = 1'b1; p0_rnw = 1'($urandom); p0_addr = 18'($urandom); p0_wdata = 8'($urandom);
            end else if (p0_req && m_k != 0 && m_port == 1'b0) begin
                p0_rnw = 1'($urandom); p0_addr = 18'($urandom); p0_wdata = 8'($urandom);
            end
            if (!p1_req && $urandom_range(0, 3) == 0) begin
                p1_req = 1'b1; p1_rnw = 1'($urandom); p1_addr = 18'($urandom); p1_wdata = 8'($urandom);
            end else if (p1_req && m_k != 0 && m_port == 1'b1) begin
                p1_rnw = 1'($urandom); p1_addr = 18'($urandom); p1_wdata = 8'($urandom);
            end
            step();
            if (p0_ack) p0_req = 1'b0;
            if (p1_ack) p1_req = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the external 256K×8 asynchronous SRAM (RAMCS_b/RAMOE_b/RAMWE_b, ADR[17:0], DAT[7:0]). It runs on clk100. It shares the SRAM between port 0 (Atom CPU side) and port 1 (loader/DMA side) using round-robin arbitration, and it generates the chip-select, output-enable and write-enable strobes with programmable pulse widths. It replaces the fixed CPU/boot pin mux in front of the SRAM pins. The top level keeps the tristate buffer (SB_IO or inferred), driven from `dat_out` and `dat_oe`.

## Interface
- RD_CYCLES, 2: cycles RAMOE_b is held low before read data is sampled (range 1..15).
- WE_CYCLES, 2: cycles RAMWE_b is held low per write (range 1..15).

- clk  in  1  system clock (clk100).
- reset_n  in  1  synchronous, active-low reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_rnw  in  1  port 0 direction: 1 = read, 0 = write.
- p0_addr  in  18  port 0 byte address.
- p0_wdata  in  8  port 0 write data.
- p0_rdata  out  8  port 0 read data, registered.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p1_req, p1_rnw, p1_addr, p1_wdata, p1_rdata, p1_ack: same as port 0, for port 1.
- busy  out  1  high whenever the FSM is not in IDLE.
- RAMCS_b, RAMOE_b, RAMWE_b  out  1 each  SRAM strobes, active low, registered.
- ADR  out  18  SRAM address, registered.
- dat_out  out  8  write data to the pads.
- dat_oe  out  1  pad output enable.
- dat_in  in  8  data from the pads.

## Operation
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values: RAMCS_b=1, RAMOE_b=1, RAMWE_b=1, ADR=0, dat_out=0, dat_oe=0, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, busy=0, last_grant=1 (so port 0 wins first), state IDLE.
- Request sampling: requests are sampled only in IDLE. On grant, the block latches rnw, addr and wdata of the granted port into internal registers. The requester's inputs are then don't-care until ack.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port != last_grant is granted. last_grant updates on grant.
- Read states: IDLE → RD (RD_CYCLES cycles) → DONE → IDLE.
  - RD: RAMCS_b=0, RAMOE_b=0, ADR=latched address.
  - On the last RD edge, dat_in is captured into the granted port's rdata.
- Write states: IDLE → WSETUP (1 cycle) → WPULSE (WE_CYCLES cycles) → WHOLD (1 cycle) → DONE → IDLE.
  - WSETUP through WHOLD: RAMCS_b=0, dat_oe=1, ADR and dat_out stable.
  - WPULSE only: RAMWE_b=0.
  - WE never changes state in the same cycle as ADR.
- DONE state: all strobes inactive, dat_oe=0. The granted port's ack is high for exactly this cycle.
- rdata: holds its value until that port's next read completes. Writes do not alter rdata.
- Request dropped before ack: protocol violation. The transaction still completes and ack still pulses.
- No-contention rule: dat_oe and RAMOE_b=0 are never active in the same cycle.
- Pulse-width counter: 4-bit down-counter, loaded with (param − 1) on state entry.

## Timing
- Let T be the IDLE cycle in which a request is granted.
- Read:
  - RD occupies T+1 .. T+RD_CYCLES.
  - ack and valid rdata appear at T+RD_CYCLES+1.
  - The next grant is possible at T+RD_CYCLES+2.
  - Defaults: 4 cycles per read (40 ns).
- Write:
  - WSETUP at T+1.
  - WPULSE at T+2 .. T+1+WE_CYCLES.
  - WHOLD at T+2+WE_CYCLES.
  - ack at T+3+WE_CYCLES.
  - Defaults: 6 cycles per write.
- Worst-case wait for port 0 with port 1 contending: one full write plus its own access = 12 cycles (120 ns). This is well inside one 1 MHz CPU cycle, so the CPU side needs no stall.
- Reset mid-transaction: all outputs return to reset values on the next edge. This includes RAMWE_b=1 and dat_oe=0. No ack is issued and the transaction is dropped.
- A request asserted in the DONE cycle is first seen in the following IDLE cycle.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with both req=1 → all strobes 1, dat_oe=0, acks 0, busy=0. After release, the first grant goes to port 0.
- Single read, defaults: p0 reads 0x12345 while dat_in=0xA5 → RAMCS_b/RAMOE_b low at T+1..T+2 with ADR=0x12345, p0_ack at T+3, p0_rdata=0xA5 and held afterwards.
- Single write, WE_CYCLES=3: p1 writes 0x5A to 0x3FFFF → dat_oe=1 for T+1..T+5, RAMWE_b low exactly at T+2..T+4, p1_ack at T+6, p1_rdata unchanged.
- Simultaneous requests after reset: p0 read and p1 write raised together → p0 serviced first. p1 is granted in the IDLE cycle after p0's DONE. Acks never overlap.
- Fairness: p0_req and p1_req held high continuously for 6 transactions → grants alternate 0,1,0,1,0,1.
- Reset during WPULSE → RAMWE_b=1 and dat_oe=0 on the next edge, no ack from that transaction, next grant goes to port 0.
